pattern_scan_ctrl: RTL and testbench
====================================

# pattern_scan_ctrl

Programmable serial pattern-scan controller. It sequences a bit-serial pattern-match datapath over a bounded window of input bits. A scan is configured once per run (pattern, length, overlap mode, window size) and started with a one-cycle request. The block counts matches and pulses `done` when the window is exhausted. It sits between the configuration/control logic and the serial data stream, replacing fixed-pattern hardwired detectors.

## Interface
- `PAT_MAX`, 8: maximum pattern length in bits (2..16).
- `CNT_W`, 8: width of the match counter.
- `WIN_W`, 16: width of the window-length field.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `cfg_pat` input PAT_MAX: pattern; bit `cfg_len-1` is matched first, bit 0 last.
- `cfg_len` input $clog2(PAT_MAX+1): pattern length in bits.
- `cfg_ovl` input 1: 1 = overlapping matches allowed; 0 = history clears after a match.
- `cfg_win` input WIN_W: number of valid input bits to scan.
- `start` input 1: one-cycle run request; sampled only in IDLE.
- `in_valid` input 1: `in_bit` is valid this cycle.
- `in_bit` input 1: serial data.
- `busy` output 1: high while in SCAN.
- `match` output 1: one-cycle pulse per detected match.
- `match_cnt` output CNT_W: matches in the current or last run.
- `done` output 1: one-cycle pulse at the end of a run.
- `err` output 1: one-cycle pulse on a rejected start.

## Operation
- States: IDLE, SCAN, DONE. Reset (`rst`=0 at a clock edge) forces IDLE and clears all outputs to 0, including `match_cnt`, the history register, the valid-bit count and the consumed count.
- **IDLE with `start`=1 and a valid config:**
  - Valid config means 1 ≤ `cfg_len` ≤ PAT_MAX and `cfg_win` ≠ 0.
  - Latch `cfg_*` into shadow registers. Later `cfg_*` changes have no effect until the next start.
  - Clear history, valid-bit count, consumed count and `match_cnt`.
  - Go to SCAN.
- **IDLE with `start`=1 and an invalid config:** pulse `err` for one cycle, stay in IDLE, leave `match_cnt` unchanged.
- **SCAN, on each `in_valid`=1 cycle:**
  - Shift `in_bit` into the history LSB.
  - Increment the consumed count.
  - Increment the valid-bit count, saturating at `cfg_len`.
- **Match condition:** valid-bit count after the shift ≥ `cfg_len` AND history[`cfg_len`-1:0] == `cfg_pat`[`cfg_len`-1:0].
- **On a match:**
  - `match` pulses.
  - `match_cnt` increments, saturating at 2^CNT_W−1.
  - If `cfg_ovl`=0, the valid-bit count resets to 0, so the next match needs `cfg_len` fresh bits.
- **End of window:** when the consumed count reaches `cfg_win`, go to DONE. A match on the final bit is still counted.
- `in_valid`=0 cycles stall the scan with no state change. `in_valid` is ignored outside SCAN.
- `start` is ignored in SCAN and DONE.
- **DONE:** lasts one cycle, `done`=1, then return to IDLE. `match_cnt` holds its value until the next accepted start or reset.

## Timing
- `start` accepted at edge N: `busy`=1 from cycle N+1.
- Bit accepted at edge M that completes a match: `match`=1 and the updated `match_cnt` are visible in cycle M+1. All outputs are registered.
- Final window bit accepted at edge M: in cycle M+1, `busy`=0 and `done`=1 (with `match`=1 if the final bit matched). IDLE in cycle M+2.
- Back-to-back runs: `start` may be asserted in the cycle `done` is high. It is sampled at the DONE→IDLE edge and ignored; it must be re-asserted in IDLE.
- Minimum run duration: `cfg_win` + 2 cycles from `start` to IDLE.
- Reset mid-SCAN: IDLE on the next edge, no `done`, `match_cnt`=0.

## Configuration
- `PSC_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in SCAN returns to IDLE on the next edge.
  - `done` and `match` are not pulsed on that edge; `match_cnt` keeps its partial value; `busy` drops.
  - `abort` has priority over a match or end of window in the same cycle.
  - `abort` is ignored in IDLE and DONE.
- `PSC_ABORT_EN` undefined: the port does not exist, and a run ends only via window exhaustion or reset.

## Test plan
- Overlap run: pat=10101, len=5, ovl=1, win=9, stream 1,0,1,0,1,0,1,0,1 (in_valid continuous) -> `match` after bits 5, 7 and 9; `match_cnt`=3; `done` in the same cycle as the third `match`.
- Non-overlap run: same stream, ovl=0 -> single `match` after bit 5; `match_cnt`=1; `done` after bit 9.
- Stalls: same as the overlap run but `in_valid`=0 on every other cycle -> identical match sequence and `match_cnt`=3; `done` delayed to cycle 18 after `start`.
- Bad config: len=0, start -> `err`=1 for one cycle, `busy` stays 0, `match_cnt` unchanged. Then len=9 with PAT_MAX=8 -> `err`.
- Counter saturation with CNT_W=2: pat=1, len=1, win=6, all ones -> `match_cnt`=3, six `match` pulses. Reset mid-SCAN -> IDLE and `match_cnt`=0 next cycle.
- With `PSC_ABORT_EN`: abort after 3 bits of the overlap-run stimulus -> no `done`, `match_cnt`=0, IDLE next cycle. Abort in the same cycle as a completing bit -> no `match`, no count increment.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: sequences a bit-serial pattern matcher over a bounded window and counts matches.
// Define PSC_ABORT_EN to add an abort input that ends a scan early.
module pattern_scan_ctrl #(
   parameter int PAT_MAX = 8,
   parameter int CNT_W   = 8,
   parameter int WIN_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef PSC_ABORT_EN
   input  logic                         abort,
`endif
   input  logic [PAT_MAX-1:0]           cfg_pat,
   input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
   input  logic                         cfg_ovl,
   input  logic [WIN_W-1:0]             cfg_win,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic                         in_bit,
   output logic                         busy,
   output logic                         match,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         done,
   output logic                         err
);
   localparam int LW = $clog2(PAT_MAX + 1);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_n;
   logic [PAT_MAX-1:0] pat_q, hist, hist_n, mask;
   logic [LW-1:0] len_q, vcnt, vcnt_inc, vcnt_n;
   logic ovl_q;
   logic [WIN_W-1:0] win_q, used, used_n;
   logic [CNT_W-1:0] cnt_n;
   logic cfg_ok, accept, step, hit, last, abort_req, match_n, err_n;
`ifdef PSC_ABORT_EN
   assign abort_req = state == SCAN && abort;
`else
   assign abort_req = 1'b0;
`endif
   // abort wins over any bit arriving in the same cycle, so a stalled or aborted cycle never steps
   always_comb begin
      cfg_ok   = cfg_len != '0 && cfg_len <= LW'(PAT_MAX) && cfg_win != '0;
      accept   = state == IDLE && start && cfg_ok;
      step     = state == SCAN && in_valid && !abort_req;
      mask     = ~({PAT_MAX{1'b1}} << len_q);
      hist_n   = {hist[PAT_MAX-2:0], in_bit};
      vcnt_inc = vcnt < len_q ? vcnt + 1'b1 : vcnt;
      hit      = step && vcnt_inc >= len_q && (hist_n & mask) == (pat_q & mask);
      used_n   = used + 1'b1;
      last     = step && used_n == win_q;
   end
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_n;
   end
   always_comb begin
      state_n = state == IDLE ? (accept ? SCAN : IDLE) :
                state == SCAN ? (abort_req ? IDLE : last ? DONE : SCAN) : IDLE;
   end
   always_comb begin
      match_n = hit;
      err_n   = state == IDLE && start && !cfg_ok;
      cnt_n   = accept ? '0 : hit && !(&match_cnt) ? match_cnt + 1'b1 : match_cnt;
      vcnt_n  = accept || (hit && !ovl_q) ? '0 : step ? vcnt_inc : vcnt;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         match     <= 1'b0;
         err       <= 1'b0;
         match_cnt <= '0;
         vcnt      <= '0;
         hist      <= '0;
         used      <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         ovl_q     <= 1'b0;
         win_q     <= '0;
      end else begin
         busy      <= state_n == SCAN;
         done      <= state_n == DONE;
         match     <= match_n;
         err       <= err_n;
         match_cnt <= cnt_n;
         vcnt      <= vcnt_n;
         if (accept) begin
            pat_q <= cfg_pat;
            len_q <= cfg_len;
            ovl_q <= cfg_ovl;
            win_q <= cfg_win;
            hist  <= '0;
            used  <= '0;
         end else if (step) begin
            hist <= hist_n;
            used <= used_n;
         end
      end
   end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed scoreboard bench for pattern_scan_ctrl (CNT_W=2 to reach saturation).
module tb_pattern_scan_ctrl;
   localparam int PAT_MAX = 8;
   localparam int CNT_W   = 2;
   localparam int WIN_W   = 16;
   logic clk = 1'b0;
   logic rst, start, in_valid, in_bit, cfg_ovl;
   logic abort = 1'b0;
   logic [PAT_MAX-1:0] cfg_pat;
   logic [3:0] cfg_len;
   logic [WIN_W-1:0] cfg_win;
   logic busy, match, done, err;
   logic [CNT_W-1:0] match_cnt;
   typedef struct packed {
      logic busy;
      logic match;
      logic done;
      logic err;
      logic [CNT_W-1:0] cnt;
   } exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;
   int cyc = 0, start_at = 0, done_at = 0, last_match_at = 0;
   int n_match = 0, n_done = 0, n_err = 0;
   string phase = "init";
   int ms = 0, m_len = 0, m_fresh = 0, m_used = 0, m_cnt = 0;
   logic [PAT_MAX-1:0] m_pat;
   logic m_ovl;
   logic [WIN_W-1:0] m_win;
   logic bits[$];

   pattern_scan_ctrl #(.PAT_MAX(PAT_MAX), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk(clk),
      .rst(rst),
`ifdef PSC_ABORT_EN
      .abort(abort),
`endif
      .cfg_pat(cfg_pat),
      .cfg_len(cfg_len),
      .cfg_ovl(cfg_ovl),
      .cfg_win(cfg_win),
      .start(start),
      .in_valid(in_valid),
      .in_bit(in_bit),
      .busy(busy),
      .match(match),
      .match_cnt(match_cnt),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, expv);
      end
   endtask

   // Reference: bit history kept as a plain list, pattern compared bit by bit against its tail.
   task automatic cycle();
      exp_t e, o;
      bit hit;
      e = '0;
      if (!rst) begin
         ms = 0; m_cnt = 0; m_fresh = 0; m_used = 0;
         bits.delete();
      end else if (ms == 0) begin
         if (start) begin
            if (cfg_len >= 1 && cfg_len <= PAT_MAX && cfg_win != 0) begin
               m_pat = cfg_pat; m_len = int'(cfg_len); m_ovl = cfg_ovl; m_win = cfg_win;
               bits.delete(); m_fresh = 0; m_used = 0; m_cnt = 0; ms = 1;
            end else e.err = 1'b1;
         end
      end else if (ms == 1) begin
         if (abort) ms = 0;
         else if (in_valid) begin
            bits.push_back(in_bit);
            m_used++;
            m_fresh++;
            hit = m_fresh >= m_len;
            for (int k = 0; k < m_len; k++)
               if (hit && bits[bits.size() - 1 - k] !== m_pat[k]) hit = 0;
            if (hit) begin
               e.match = 1'b1;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
               if (!m_ovl) m_fresh = 0;
            end
            if (m_used == int'(m_win)) ms = 2;
         end
      end else ms = 0;
      e.busy = ms == 1;
      e.done = ms == 2;
      e.cnt = CNT_W'(m_cnt);
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      o = sb.pop_front();
      check("busy", 32'(busy), 32'(o.busy));
      check("match", 32'(match), 32'(o.match));
      check("done", 32'(done), 32'(o.done));
      check("err", 32'(err), 32'(o.err));
      check("match_cnt", 32'(match_cnt), 32'(o.cnt));
      if (match === 1'b1) begin n_match++; last_match_at = cyc; end
      if (done === 1'b1) begin n_done++; done_at = cyc; end
      if (err === 1'b1) n_err++;
   endtask

   task automatic scan(input string name, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic [15:0] win, input logic [31:0] stream,
                       input int n, input bit stall, input int abort_at);
      phase = name;
      n_match = 0; n_done = 0; done_at = 0; last_match_at = 0;
      cfg_pat = pat; cfg_len = len; cfg_ovl = ovl; cfg_win = win;
      start = 1'b1;
      cycle();
      start_at = cyc;
      start = 1'b0;
      cfg_pat = ~pat; cfg_len = 4'd1; cfg_ovl = ~ovl;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_bit = stream[n - 1 - i];
         if (i == abort_at) begin
            abort = 1'b1;
            cycle();
            abort = 1'b0;
            break;
         end
         cycle();
         if (stall && i < n - 1) begin
            in_valid = 1'b0;
            in_bit = ~in_bit;
            cycle();
         end
      end
      in_valid = 1'b0;
      if (abort_at < 0) begin
         start = 1'b1;
         cycle();
         start = 1'b0;
      end
      cycle();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0; cfg_win = '0;
      phase = "reset";
      cycle();
      cycle();
      rst = 1'b1;
      cycle();

      scan("overlap", 8'h15, 4'd5, 1'b1, 16'd9, 32'h155, 9, 1'b0, -1);
      check("n_match", 32'(n_match), 32'd3);
      check("final_cnt", 32'(match_cnt), 32'd3);
      check("done_lat", 32'(done_at - start_at), 32'd9);
      check("third_match_lat", 32'(last_match_at - start_at), 32'd9);

      scan("nonoverlap", 8'h15, 4'd5, 1'b0, 16'd9, 32'h155, 9, 1'b0, -1);
      check("n_match", 32'(n_match), 32'd1);
      check("final_cnt", 32'(match_cnt), 32'd1);
      check("done_lat", 32'(done_at - start_at), 32'd9);

      scan("stall", 8'h15, 4'd5, 1'b1, 16'd9, 32'h155, 9, 1'b1, -1);
      check("n_match", 32'(n_match), 32'd3);
      check("final_cnt", 32'(match_cnt), 32'd3);
      check("done_lat", 32'(done_at - start_at), 32'd17);
      check("n_done", 32'(n_done), 32'd1);

      phase = "badcfg";
      n_err = 0;
      cfg_pat = 8'h15; cfg_win = 16'd5; cfg_len = 4'd0; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cfg_len = 4'd9; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      cfg_len = 4'd3; cfg_win = 16'd0; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      check("n_err", 32'(n_err), 32'd3);
      check("cnt_kept", 32'(match_cnt), 32'd3);

      scan("saturate", 8'h01, 4'd1, 1'b0, 16'd6, 32'h3f, 6, 1'b0, -1);
      check("n_match", 32'(n_match), 32'd6);
      check("final_cnt", 32'(match_cnt), 32'd3);

      phase = "midreset";
      n_done = 0;
      cfg_pat = 8'h01; cfg_len = 4'd1; cfg_ovl = 1'b1; cfg_win = 16'd10; start = 1'b1;
      cycle();
      start = 1'b0;
      in_valid = 1'b1; in_bit = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0;
      cycle();
      check("busy_after_rst", 32'(busy), 32'd0);
      check("cnt_after_rst", 32'(match_cnt), 32'd0);
      rst = 1'b1;
      cycle();
      in_valid = 1'b0;
      cycle();
      check("n_done", 32'(n_done), 32'd0);

`ifdef PSC_ABORT_EN
      scan("abort3", 8'h15, 4'd5, 1'b1, 16'd9, 32'h155, 9, 1'b0, 3);
      check("n_done", 32'(n_done), 32'd0);
      check("final_cnt", 32'(match_cnt), 32'd0);
      check("busy", 32'(busy), 32'd0);
      scan("abort_on_hit", 8'h15, 4'd5, 1'b1, 16'd9, 32'h155, 9, 1'b0, 4);
      check("n_match", 32'(n_match), 32'd0);
      check("n_done", 32'(n_done), 32'd0);
      check("final_cnt", 32'(match_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
